// File: rtl/regs_trace_buffer.sv
// Change-capture trace buffer: every change seen on regs_i while tracing is enabled
// is pushed as {timestamp, value} into a show-ahead FIFO drained by a consumer.
module regs_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int TS_W  = 16
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic [13:0]            regs_i,
    input  logic                   trace_en_i,
    input  logic                   rd_ready_i,
    output logic                   rd_valid_o,
    output logic [TS_W+13:0]       rd_data_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   overflow_o,
    output logic [7:0]             drop_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = TS_W + 14;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [TS_W-1:0] r_ts;
    logic [13:0]     r_prev;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            r_overflow;
    logic [7:0]      r_drop_cnt;
    logic [DW-1:0]   r_mem [DEPTH];

    logic            w_cap_req;
    logic            w_valid;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic [DW-1:0]   w_wr_data;

    // A full FIFO still accepts a capture when the head is leaving on the same edge.
    assign w_cap_req = trace_en_i && (regs_i != r_prev);
    assign w_valid   = (r_count != '0);
    assign w_full    = (r_count == FULL_CNT);
    assign w_pop     = w_valid && rd_ready_i;
    assign w_push    = w_cap_req && (!w_full || w_pop);
    assign w_drop    = w_cap_req && w_full && !w_pop;
    assign w_wr_data = {r_ts, regs_i};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            r_ts       <= '0;
            r_prev     <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_ts   <= r_ts + TS_W'(1);
            r_prev <= regs_i;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase

            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 8'hFF) begin
                    r_drop_cnt <= r_drop_cnt + 8'd1;
                end
            end
        end
    end

    // NOTE: storage has no reset; stale entries are hidden by the rd_valid_o gate below.
    always_ff @(posedge clock_i) begin
        if (reset_i && w_push) begin
            r_mem[r_wr_ptr] <= w_wr_data;
        end
    end

    assign rd_valid_o = w_valid;
    assign rd_data_o  = w_valid ? r_mem[r_rd_ptr] : '0;
    assign count_o    = r_count;
    assign overflow_o = r_overflow;
    assign drop_cnt_o = r_drop_cnt;

endmodule

// File: tb/tb_regs_trace_buffer.sv
// Directed bench for regs_trace_buffer: a vector table for single-edge behaviour,
// then hand sequences for overflow, saturation, reset and timestamp wrap.
module tb_regs_trace_buffer;

    localparam int DEPTH = 16;
    localparam int TS_W  = 16;
    localparam int DW    = TS_W + 14;
    localparam int NVEC  = 14;

    logic          clock_i = 1'b0;
    logic          reset_i = 1'b0;
    logic [13:0]   regs_i = '0;
    logic          trace_en_i = 1'b0;
    logic          rd_ready_i = 1'b0;
    logic          rd_valid_o;
    logic [DW-1:0] rd_data_o;
    logic [4:0]    count_o;
    logic          overflow_o;
    logic [7:0]    drop_cnt_o;

    regs_trace_buffer #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .regs_i     (regs_i),
        .trace_en_i (trace_en_i),
        .rd_ready_i (rd_ready_i),
        .rd_valid_o (rd_valid_o),
        .rd_data_o  (rd_data_o),
        .count_o    (count_o),
        .overflow_o (overflow_o),
        .drop_cnt_o (drop_cnt_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct {
        logic [13:0]   regs;
        logic          en;
        logic          rdy;
        logic          valid;
        logic [DW-1:0] data;
        logic [4:0]    count;
        logic          ovf;
        logic [7:0]    drop;
    } vec_t;

    vec_t          vecs [NVEC];
    int            n_checks = 0;
    int            n_fail = 0;
    logic [15:0]   ts_m = '0;
    logic [13:0]   v = 14'h0100;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] exp_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string name, input logic valid, input logic [DW-1:0] data,
                               input logic [4:0] count, input logic ovf, input logic [7:0] drop);
        check({name, " valid"}, 64'(rd_valid_o), 64'(valid));
        check({name, " data"},  64'(rd_data_o),  64'(data));
        check({name, " count"}, 64'(count_o),    64'(count));
        check({name, " ovf"},   64'(overflow_o), 64'(ovf));
        check({name, " drop"},  64'(drop_cnt_o), 64'(drop));
    endtask

    // One clock edge; ts_m tracks the timestamp the DUT will use on the next edge.
    task automatic step();
        @(posedge clock_i);
        #1;
        ts_m = reset_i ? ts_m + 16'd1 : 16'd0;
    endtask

    // Drive a new regs value and record it as expected if the FIFO can take it.
    task automatic change(input logic will_push);
        v = v + 14'd1;
        regs_i = v;
        if (will_push) exp_q.push_back({ts_m, v});
        step();
    endtask

    task automatic drain_all(input string name);
        rd_ready_i = 1'b1;
        while (exp_q.size() > 0) begin
            exp_e = exp_q.pop_front();
            check({name, " head valid"}, 64'(rd_valid_o), 64'd1);
            check({name, " head data"},  64'(rd_data_o),  64'(exp_e));
            step();
        end
        rd_ready_i = 1'b0;
        check({name, " empty valid"}, 64'(rd_valid_o), 64'd0);
        check({name, " empty data"},  64'(rd_data_o),  64'd0);
        check({name, " empty count"}, 64'(count_o),    64'd0);
    endtask

    initial begin
        //          regs      en    rdy   valid data                  cnt  ovf   drop
        vecs[0]  = '{14'h0000, 1'b1, 1'b0, 1'b0, '0,                  5'd0, 1'b0, 8'd0};
        vecs[1]  = '{14'h0000, 1'b1, 1'b0, 1'b0, '0,                  5'd0, 1'b0, 8'd0};
        vecs[2]  = '{14'h0000, 1'b1, 1'b0, 1'b0, '0,                  5'd0, 1'b0, 8'd0};
        vecs[3]  = '{14'h0005, 1'b1, 1'b0, 1'b1, {16'd3, 14'h0005},   5'd1, 1'b0, 8'd0};
        vecs[4]  = '{14'h0005, 1'b1, 1'b0, 1'b1, {16'd3, 14'h0005},   5'd1, 1'b0, 8'd0};
        vecs[5]  = '{14'h0005, 1'b1, 1'b1, 1'b0, '0,                  5'd0, 1'b0, 8'd0};
        vecs[6]  = '{14'h0005, 1'b1, 1'b1, 1'b0, '0,                  5'd0, 1'b0, 8'd0};
        vecs[7]  = '{14'h0009, 1'b1, 1'b1, 1'b1, {16'd7, 14'h0009},   5'd1, 1'b0, 8'd0};
        vecs[8]  = '{14'h000A, 1'b1, 1'b1, 1'b1, {16'd8, 14'h000A},   5'd1, 1'b0, 8'd0};
        vecs[9]  = '{14'h000A, 1'b0, 1'b0, 1'b1, {16'd8, 14'h000A},   5'd1, 1'b0, 8'd0};
        vecs[10] = '{14'h3FFF, 1'b0, 1'b0, 1'b1, {16'd8, 14'h000A},   5'd1, 1'b0, 8'd0};
        vecs[11] = '{14'h3FFF, 1'b1, 1'b0, 1'b1, {16'd8, 14'h000A},   5'd1, 1'b0, 8'd0};
        vecs[12] = '{14'h1234, 1'b1, 1'b1, 1'b1, {16'd12, 14'h1234},  5'd1, 1'b0, 8'd0};
        vecs[13] = '{14'h1234, 1'b1, 1'b1, 1'b0, '0,                  5'd0, 1'b0, 8'd0};

        // Reset for two edges, then the vector table.
        trace_en_i = 1'b1;
        reset_i = 1'b0;
        step();
        step();
        check_state("reset", 1'b0, '0, 5'd0, 1'b0, 8'd0);
        reset_i = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            regs_i     = vecs[i].regs;
            trace_en_i = vecs[i].en;
            rd_ready_i = vecs[i].rdy;
            step();
            check_state($sformatf("vec%0d", i), vecs[i].valid, vecs[i].data,
                        vecs[i].count, vecs[i].ovf, vecs[i].drop);
        end

        // Constant input: no captures. Disabled tracing: no captures, prev still follows.
        rd_ready_i = 1'b0;
        trace_en_i = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            check($sformatf("hold count %0d", i), 64'(count_o), 64'd0);
        end
        trace_en_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            change(1'b0);
            check($sformatf("disabled count %0d", i), 64'(count_o), 64'd0);
        end
        trace_en_i = 1'b1;
        step();
        check("prev tracked count", 64'(count_o), 64'd0);
        change(1'b1);
        check("reenable count", 64'(count_o), 64'd1);
        drain_all("reenable");

        // 18 changes with no reads: 16 stored, 2 dropped.
        for (int i = 0; i < 18; i++) change(exp_q.size() < DEPTH);
        check_state("overflow", 1'b1, exp_q[0], 5'd16, 1'b1, 8'd2);
        drain_all("drain18");

        // Full FIFO with a simultaneous pop and push.
        for (int i = 0; i < DEPTH; i++) change(1'b1);
        check("refill count", 64'(count_o), 64'd16);
        exp_q.pop_front();
        rd_ready_i = 1'b1;
        change(1'b1);
        rd_ready_i = 1'b0;
        check_state("full push+pop", 1'b1, exp_q[0], 5'd16, 1'b1, 8'd2);

        // Drop counter saturates; contents untouched by dropped captures.
        for (int i = 0; i < 260; i++) change(1'b0);
        check_state("saturate", 1'b1, exp_q[0], 5'd16, 1'b1, 8'd255);
        drain_all("drain_sat");
        check("sticky ovf", 64'(overflow_o), 64'd1);
        check("sticky drop", 64'(drop_cnt_o), 64'd255);

        // Mid-operation reset with 5 entries queued.
        for (int i = 0; i < 5; i++) change(1'b1);
        check("pre-reset count", 64'(count_o), 64'd5);
        reset_i = 1'b0;
        step();
        exp_q.delete();
        check_state("midreset", 1'b0, '0, 5'd0, 1'b0, 8'd0);
        reset_i = 1'b1;
        change(1'b1);
        check("ts restart data", 64'(rd_data_o), 64'({16'd0, v}));
        drain_all("post_reset");

        // Timestamp wrap: captures on edges with ts 0xFFFF and 0x0000.
        while (ts_m != 16'hFFFF) step();
        change(1'b1);
        change(1'b1);
        check("wrap count", 64'(count_o), 64'd2);
        check("wrap ts hi", 64'(exp_q[0][DW-1:14]), 64'h0000_FFFF);
        check("wrap ts lo", 64'(exp_q[1][DW-1:14]), 64'h0000_0000);
        drain_all("wrap");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
